precalc_loader: RTL and testbench

Streaming writer for the display's precalculation table. Receives a framed byte stream from the host link and assembles it into 16-bit table words. Writes the words sequentially into the write port of the table RAM, which the display engine reads. A trailing checksum byte is verified, and the result is published as `table_valid` or `error`.

---
 rtl/precalc_loader.sv | 135 +++++++++++++
 tb/tb_precalc_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/precalc_loader.sv
// Byte-stream loader for the precalculation table: hunts for SYNC, packs byte
// pairs into 16-bit words, writes them sequentially and verifies an XOR checksum.
module precalc_loader #(
    parameter int          ADDR_W  = 15,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              table_valid,
    output logic              error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LO, HI, CSUM} state_t;

    state_t            state, state_next;
    logic              hs;
    logic              is_sync;
    logic              tout;
    logic              last_word;
    logic [7:0]        lo_byte;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] cnt;
    logic [TW-1:0]     tcnt;

    assign hs        = in_valid && in_ready;
    assign is_sync   = (in_data == SYNC);
    assign last_word = (cnt == {ADDR_W{1'b1}});
    // Fires when this would be the TIMEOUT-th consecutive cycle without a handshake;
    // a handshake in the same cycle takes priority.
    assign tout      = (state != IDLE) && !hs && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (hs && is_sync) state_next = LO;
            LO: begin
                if (hs)        state_next = HI;
                else if (tout) state_next = IDLE;
            end
            HI: begin
                if (hs)        state_next = last_word ? CSUM : LO;
                else if (tout) state_next = IDLE;
            end
            CSUM: if (hs || tout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            table_valid <= 1'b0;
            error       <= 1'b0;
            cnt         <= '0;
            tcnt        <= '0;
        end else begin
            in_ready <= 1'b1;
            wr_en    <= 1'b0;

            if (state == IDLE || hs) tcnt <= '0;
            else                     tcnt <= tcnt + 1'b1;

            case (state)
                IDLE: begin
                    if (hs && is_sync) begin
                        busy        <= 1'b1;
                        table_valid <= 1'b0;
                        error       <= 1'b0;
                        cnt         <= '0;
                    end
                end
                HI: begin
                    if (hs) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= {in_data, lo_byte};
                        cnt     <= cnt + 1'b1;
                    end
                end
                CSUM: begin
                    if (hs) begin
                        busy        <= 1'b0;
                        table_valid <= (in_data == csum);
                        error       <= (in_data != csum);
                    end
                end
                default: ;
            endcase

            if (tout) begin
                busy  <= 1'b0;
                error <= 1'b1;
            end
        end
    end

    // Byte assembly and checksum accumulation
    always_ff @(posedge clk) begin
        if (hs) begin
            case (state)
                IDLE: if (is_sync) csum <= '0;
                LO: begin
                    lo_byte <= in_data;
                    csum    <= csum ^ in_data;
                end
                HI:      csum <= csum ^ in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_precalc_loader.sv
// Randomised/directed bench for precalc_loader (ADDR_W=2, TIMEOUT=8) against a
// table-and-checksum reference model.
module tb_precalc_loader;

    localparam int         ADDR_W  = 2;
    localparam int         NW      = 1 << ADDR_W;
    localparam int         NB      = 2 * NW;
    localparam int         TIMEOUT = 8;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              table_valid;
    logic              error;

    int checks = 0;
    int errors = 0;
    int wcount = 0;

    logic [7:0]  fb      [NB];
    logic [15:0] mem     [NW];
    logic [15:0] exp_mem [NW];

    precalc_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .table_valid(table_valid), .error(error)
    );

    always #5 clk = ~clk;

    // RAM model fed by the write port
    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            wcount++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap == 0) return 0;
        if ($urandom_range(2, 0) == 0) return maxgap;
        return int'($urandom_range(maxgap, 0));
    endfunction

    // Present one byte after `gap` idle cycles; returns just after the consuming edge.
    task automatic put(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
        #1;
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NB; i++) x ^= fb[i];
        return x;
    endfunction

    task automatic random_bytes();
        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic load_basic();
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    endtask

    // Sends SYNC + fb[] + cs and checks every write and the final verdict.
    task automatic send_frame(input string tag, input logic [7:0] cs, input int maxgap);
        bit good;
        int w0;
        good = (cs == frame_xor());
        w0   = wcount;
        put(SYNC, pick_gap(maxgap));
        chk({tag, ".busy_rise"}, busy, 1);
        chk({tag, ".flags_clr"}, {table_valid, error}, 2'b00);
        for (int w = 0; w < NW; w++) begin
            put(fb[2*w], pick_gap(maxgap));
            chk({tag, ".wr_en_lo"}, wr_en, 0);
            put(fb[2*w+1], pick_gap(maxgap));
            exp_mem[w] = {fb[2*w+1], fb[2*w]};
            chk({tag, ".wr_en_hi"}, wr_en, 1);
            chk({tag, ".wr_addr"}, wr_addr, w);
            chk({tag, ".wr_data"}, wr_data, exp_mem[w]);
        end
        put(cs, pick_gap(maxgap));
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".table_valid"}, table_valid, good);
        chk({tag, ".error"}, error, !good);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".nwrites"}, wcount - w0, NW);
        for (int w = 0; w < NW; w++) chk({tag, ".ram"}, mem[w], exp_mem[w]);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.wr", {wr_en, wr_addr, wr_data}, 0);
        chk("rst.flags", {busy, table_valid, error}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel.in_ready", in_ready, 1);

        load_basic();
        send_frame("basic", 8'h88, 0);

        load_basic();
        send_frame("badcs", 8'h00, 0);

        put(8'h00, 0);
        chk("hunt.00", busy, 0);
        put(8'hFF, 0);
        chk("hunt.FF", busy, 0);
        load_basic();
        fb[0] = SYNC;
        fb[1] = SYNC;
        send_frame("hunt", frame_xor(), 0);

        load_basic();
        send_frame("gapped", 8'h88, TIMEOUT - 1);

        put(SYNC, 0);
        for (int i = 0; i < 4; i++) put(8'(8'h30 + i), 0);
        idle_cycles(TIMEOUT - 1);
        chk("tout.pre_busy", busy, 1);
        chk("tout.pre_err", error, 0);
        idle_cycles(1);
        chk("tout.busy", busy, 0);
        chk("tout.error", error, 1);
        chk("tout.tv", table_valid, 0);
        put(8'h11, 0);
        chk("tout.idle", busy, 0);
        random_bytes();
        send_frame("after_tout", frame_xor(), 0);

        put(SYNC, 0);
        for (int i = 0; i < 4; i++) put(8'(8'hC0 + i), 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.in_ready", in_ready, 0);
        chk("mrst.wr", {wr_en, wr_addr, wr_data}, 0);
        chk("mrst.flags", {busy, table_valid, error}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        random_bytes();
        send_frame("after_rst", frame_xor(), 0);

        for (int k = 0; k < 4; k++) begin
            random_bytes();
            if (k == 2) send_frame("rand_bad", frame_xor() ^ 8'($urandom_range(255, 1)), TIMEOUT - 1);
            else        send_frame("rand", frame_xor(), TIMEOUT - 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
